// File: rtl/cpu_pkg.sv
// Shared types and encodings for the accumulator-machine controller.
// Pure declarations; no timing of its own.
// No flow control; consumers apply their own handshakes.
package cpu_pkg;

  localparam int CPU_OPCODE_WIDTH = 5;
  localparam int CPU_ALU_OP_WIDTH = 2;

  typedef enum logic [CPU_OPCODE_WIDTH-1:0] {
    OP_HLT  = 5'd0,
    OP_STO  = 5'd1,
    OP_LD   = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_EXT = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  localparam logic [CPU_ALU_OP_WIDTH-1:0] ALU_PASS = 2'b00;
  localparam logic [CPU_ALU_OP_WIDTH-1:0] ALU_ADD  = 2'b01;
  localparam logic [CPU_ALU_OP_WIDTH-1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/control_output_decoder.sv
// Maps (state, latched opcode) onto the controller's output bundle.
// Combinational; inputs are all registers so outputs never depend on live ports.
// No flow control; outputs are forced low while the controller is not running.
module control_output_decoder
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = CPU_OPCODE_WIDTH,
  parameter int ALU_OP_WIDTH = CPU_ALU_OP_WIDTH
) (
  input  logic                    run,
  input  state_t                  state,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    instr_req,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [1:0]              sel_A,
  output logic                    wr_A,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    pc_inc,
  output logic                    halted
);

  // Moore decode; every output defaults low so only the owning state raises it
  always_comb begin
    instr_req = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    sel_A     = SEL_A_MEM;
    wr_A      = 1'b0;
    alu_op    = ALU_OP_WIDTH'(ALU_PASS);
    pc_inc    = 1'b0;
    halted    = 1'b0;
    if (run) begin
      case (state)
        ST_FETCH:  instr_req = 1'b1;
        ST_DECODE: pc_inc    = 1'b1;
        ST_MEM: begin
          mem_req = 1'b1;
          mem_wr  = (opcode == OP_STO);
        end
        ST_EXEC: begin
          wr_A = 1'b1;
          case (opcode)
            OP_LD:   sel_A = SEL_A_MEM;
            OP_LDI:  sel_A = SEL_A_EXT;
            OP_ADD, OP_ADDI: begin
              sel_A  = SEL_A_ALU;
              alu_op = ALU_OP_WIDTH'(ALU_ADD);
            end
            OP_SUB, OP_SUBI: begin
              sel_A  = SEL_A_ALU;
              alu_op = ALU_OP_WIDTH'(ALU_SUB);
            end
            default: sel_A = SEL_A_MEM;
          endcase
        end
        ST_HALT:   halted = 1'b1;
        default:   halted = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore controller: fetch opcode, optional data access, one-cycle execute.
// Immediate ops 3 cycles, memory ops 4, STO 3, NOP 2 with zero-wait memories.
// Holds FETCH until instr_valid and MEM until mem_ack; stray handshakes are ignored.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = CPU_OPCODE_WIDTH,
  parameter int ALU_OP_WIDTH = CPU_ALU_OP_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] instr_opcode,
  input  logic                    instr_valid,
  output logic                    instr_req,
  input  logic                    mem_ack,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [1:0]              sel_A,
  output logic                    wr_A,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    pc_inc,
  output logic                    halted
);

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  // Cleared by reset so every output is low while rst_n is held and
  // instr_req only appears after the first edge following release.
  logic                    run_q;

  // State register and next-state sequencing; a FETCH handshake needs
  // run_q because instr_req is not yet visible before it sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      opcode_q <= '0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (run_q && instr_valid) begin
            opcode_q <= instr_opcode;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (opcode_q)
            OP_HLT:                   state <= ST_HALT;
            OP_LDI, OP_ADDI, OP_SUBI: state <= ST_EXEC;
            OP_LD, OP_ADD, OP_SUB, OP_STO: state <= ST_MEM;
            default:                  state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            state <= (opcode_q == OP_STO) ? ST_FETCH : ST_EXEC;
          end
        end
        ST_EXEC: state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  control_output_decoder #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .ALU_OP_WIDTH (ALU_OP_WIDTH)
  ) u_dec (
    .run       (run_q),
    .state     (state),
    .opcode    (opcode_q),
    .instr_req (instr_req),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .sel_A     (sel_A),
    .wr_A      (wr_A),
    .alu_op    (alu_op),
    .pc_inc    (pc_inc),
    .halted    (halted)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Output bundle is packed {instr_req, mem_req, mem_wr, sel_A, wr_A, alu_op, pc_inc, halted}.
// Inputs change on the falling edge right after the outputs are sampled there.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] instr_opcode;
  logic       instr_valid;
  logic       instr_req;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_wr;
  logic [1:0] sel_A;
  logic       wr_A;
  logic [1:0] alu_op;
  logic       pc_inc;
  logic       halted;

  logic [9:0] outs;
  int         n_vec;
  int         n_err;

  localparam logic [9:0] E_ZERO  = 10'b0_0_0_00_0_00_0_0;
  localparam logic [9:0] E_FETCH = 10'b1_0_0_00_0_00_0_0;
  localparam logic [9:0] E_DEC   = 10'b0_0_0_00_0_00_1_0;
  localparam logic [9:0] E_MEMRD = 10'b0_1_0_00_0_00_0_0;
  localparam logic [9:0] E_MEMWR = 10'b0_1_1_00_0_00_0_0;
  localparam logic [9:0] E_LD    = 10'b0_0_0_00_1_00_0_0;
  localparam logic [9:0] E_LDI   = 10'b0_0_0_01_1_00_0_0;
  localparam logic [9:0] E_ADD   = 10'b0_0_0_10_1_01_0_0;
  localparam logic [9:0] E_SUB   = 10'b0_0_0_10_1_10_0_0;
  localparam logic [9:0] E_HALT  = 10'b0_0_0_00_0_00_0_1;

  control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_opcode (instr_opcode),
    .instr_valid  (instr_valid),
    .instr_req    (instr_req),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .sel_A        (sel_A),
    .wr_A         (wr_A),
    .alu_op       (alu_op),
    .pc_inc       (pc_inc),
    .halted       (halted)
  );

  assign outs = {instr_req, mem_req, mem_wr, sel_A, wr_A, alu_op, pc_inc, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] exp);
    @(negedge clk);
    chk(tag, outs, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    instr_valid = 1'b1;
    instr_opcode = 5'd3;
    mem_ack = 1'b0;

    // reset held with a valid LDI already presented
    step("rst_hold0", E_ZERO);
    step("rst_hold1", E_ZERO);
    rst_n = 1'b1;
    step("ldi_fetch", E_FETCH);
    step("ldi_decode", E_DEC);
    step("ldi_exec", E_LDI);

    // ADD with ack arriving in the fourth MEM cycle
    instr_opcode = 5'd4;
    step("add_fetch", E_FETCH);
    step("add_decode", E_DEC);
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) step("add_mem_wait", E_MEMRD);
    mem_ack = 1'b1;
    step("add_exec", E_ADD);
    mem_ack = 1'b0;
    step("add_back_fetch", E_FETCH);
    step("fetch_hold", E_FETCH);

    // STO with immediate ack; stray ack during FETCH and DECODE
    instr_opcode = 5'd1;
    instr_valid = 1'b1;
    mem_ack = 1'b1;
    step("sto_decode", E_DEC);
    instr_valid = 1'b0;
    step("sto_mem", E_MEMWR);
    step("sto_back_fetch", E_FETCH);
    mem_ack = 1'b0;

    // undefined opcode behaves as NOP
    instr_opcode = 5'd17;
    instr_valid = 1'b1;
    step("nop_decode", E_DEC);
    instr_valid = 1'b0;
    step("nop_back_fetch", E_FETCH);
    step("nop_fetch_hold", E_FETCH);

    // SUBI with instr_valid left high through DECODE/EXEC
    instr_opcode = 5'd7;
    instr_valid = 1'b1;
    step("subi_decode", E_DEC);
    step("subi_exec", E_SUB);
    instr_valid = 1'b0;
    step("subi_back_fetch", E_FETCH);

    // LD with zero-wait memory
    instr_opcode = 5'd2;
    instr_valid = 1'b1;
    step("ld_decode", E_DEC);
    instr_valid = 1'b0;
    mem_ack = 1'b1;
    step("ld_mem", E_MEMRD);
    step("ld_exec", E_LD);
    mem_ack = 1'b0;
    step("ld_back_fetch", E_FETCH);

    // HLT, then handshake noise must not wake it
    instr_opcode = 5'd0;
    instr_valid = 1'b1;
    step("hlt_decode", E_DEC);
    step("hlt_enter", E_HALT);
    for (int i = 0; i < 4; i++) begin
      instr_valid = i[0];
      mem_ack = ~i[0];
      step("hlt_sticky", E_HALT);
    end
    #2 rst_n = 1'b0;
    #1 chk("hlt_async_rst", outs, E_ZERO);
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    step("hlt_rst_hold", E_ZERO);
    rst_n = 1'b1;
    step("post_hlt_fetch", E_FETCH);

    // reset asserted while STO waits for ack
    instr_opcode = 5'd1;
    instr_valid = 1'b1;
    step("sto2_decode", E_DEC);
    instr_valid = 1'b0;
    step("sto2_mem", E_MEMWR);
    step("sto2_mem_wait", E_MEMWR);
    #2 rst_n = 1'b0;
    #1 chk("sto2_async_rst", outs, E_ZERO);
    mem_ack = 1'b1;
    step("sto2_rst_hold", E_ZERO);
    rst_n = 1'b1;
    mem_ack = 1'b0;
    step("sto2_post_fetch", E_FETCH);
    step("sto2_fetch_hold", E_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
